// File: rtl/prt_ingress_writer.sv
// prt_ingress_writer: turns a framed byte stream from the receive MAC into the
// PRT start/write/finish handshake, truncates frames longer than MAX_LEN,
// reports each committed frame and keeps saturating statistics counters.
// Optional feature macro: PRT_INGRESS_DROP_EN (discard whole frames while the
// PRT has no free slot instead of backpressuring the MAC).
module prt_ingress_writer #(
    parameter int MAX_LEN = 1500,
    parameter int SLOT_W  = 1,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              EN_start_writing_prt_entry,
    input  logic              RDY_start_writing_prt_entry,
    input  logic [SLOT_W-1:0] start_writing_prt_entry,
    input  logic              is_prt_slot_free,
    output logic [7:0]        write_prt_entry_data,
    output logic              EN_write_prt_entry,
    input  logic              RDY_write_prt_entry,
    output logic              EN_finish_writing_prt_entry,
    input  logic              RDY_finish_writing_prt_entry,
    output logic              frame_done,
    output logic [SLOT_W-1:0] frame_slot,
    output logic [10:0]       frame_len,
    output logic              frame_trunc,
    output logic [CNT_W-1:0]  cnt_ok,
    output logic [CNT_W-1:0]  cnt_trunc,
    output logic [CNT_W-1:0]  cnt_drop
);
    localparam int LEN_W = 11;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam int CNT_OK    = 0;
    localparam int CNT_TRUNC = 1;
`ifdef PRT_INGRESS_DROP_EN
    localparam int CNT_DROP  = 2;
    localparam int NUM_CNT   = 3;
`else
    localparam int NUM_CNT   = 2;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_FINISH = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              trunc_q, trunc_d;

    logic              done_q;
    logic [SLOT_W-1:0] fslot_q;
    logic [LEN_W-1:0]  flen_q;
    logic              ftrunc_q;

    logic byte_acc;
    logic len_hit;
    logic fin_hs;

    // A byte is consumed into the PRT only in DATA while the PRT accepts it.
    assign byte_acc = (state_q == ST_DATA) && s_valid && RDY_write_prt_entry;
    // This byte would be the MAX_LEN-th byte of the frame.
    assign len_hit  = ((len_q + LEN_W'(1)) == MAX_LEN_L);
    assign fin_hs   = (state_q == ST_FINISH) && RDY_finish_writing_prt_entry;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid && RDY_start_writing_prt_entry) begin
                    state_d = ST_DATA;
                end
`ifdef PRT_INGRESS_DROP_EN
                else if (s_valid && !is_prt_slot_free) begin
                    state_d = ST_DROP;
                end
`endif
            end
            ST_DATA: begin
                if (byte_acc && (s_last || len_hit)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (RDY_finish_writing_prt_entry) begin
                    state_d = trunc_q ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN, ST_DROP: begin
                // s_ready is high here, so a valid last byte is always accepted
                if (s_valid && s_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; EN_start is gated by RST_N so reset forces every output low
    always_comb begin
        s_ready                     = 1'b0;
        EN_start_writing_prt_entry  = 1'b0;
        EN_write_prt_entry          = 1'b0;
        EN_finish_writing_prt_entry = 1'b0;
        write_prt_entry_data        = '0;
        case (state_q)
            ST_IDLE: begin
                EN_start_writing_prt_entry = RST_N && s_valid && RDY_start_writing_prt_entry;
            end
            ST_DATA: begin
                s_ready              = RDY_write_prt_entry;
                EN_write_prt_entry   = s_valid && RDY_write_prt_entry;
                write_prt_entry_data = s_data;
            end
            ST_FINISH: begin
                EN_finish_writing_prt_entry = RDY_finish_writing_prt_entry;
            end
            ST_DRAIN, ST_DROP: begin
                s_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Per-frame length, slot and truncation bookkeeping
    always_comb begin
        len_d   = len_q;
        slot_d  = slot_q;
        trunc_d = trunc_q;
        if (state_q == ST_IDLE) begin
            len_d   = '0;
            trunc_d = 1'b0;
        end else if (byte_acc) begin
            len_d = len_q + LEN_W'(1);
            // The PRT presents the chosen slot for the whole write phase
            if (len_q == '0) begin
                slot_d = start_writing_prt_entry;
            end
            if (!s_last && len_hit) begin
                trunc_d = 1'b1;
            end
        end
    end

    // Frame bookkeeping registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_q   <= '0;
            slot_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            len_q   <= len_d;
            slot_q  <= slot_d;
            trunc_q <= trunc_d;
        end
    end

    // Committed-frame report, held until the next commit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done_q   <= 1'b0;
            fslot_q  <= '0;
            flen_q   <= '0;
            ftrunc_q <= 1'b0;
        end else begin
            done_q <= fin_hs;
            if (fin_hs) begin
                fslot_q  <= slot_q;
                flen_q   <= len_q;
                ftrunc_q <= trunc_q;
            end
        end
    end

    assign frame_done  = done_q;
    assign frame_slot  = fslot_q;
    assign frame_len   = flen_q;
    assign frame_trunc = ftrunc_q;

    logic [NUM_CNT-1:0]            cnt_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_all;

    assign cnt_inc[CNT_OK]    = fin_hs;
    assign cnt_inc[CNT_TRUNC] = fin_hs && trunc_q;
`ifdef PRT_INGRESS_DROP_EN
    assign cnt_inc[CNT_DROP]  = (state_q == ST_DROP) && s_valid && s_last;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Saturating increment: holds at all-ones
            always_comb begin
                cnt_d = cnt_q;
                if (cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Counter register
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign cnt_ok    = cnt_all[CNT_OK];
    assign cnt_trunc = cnt_all[CNT_TRUNC];
`ifdef PRT_INGRESS_DROP_EN
    assign cnt_drop  = cnt_all[CNT_DROP];
`else
    assign cnt_drop  = '0;
    // Slot availability only matters when frames may be dropped
    logic unused_slot_free;
    assign unused_slot_free = is_prt_slot_free;
`endif

endmodule

// File: tb/tb_prt_ingress_writer.sv
// Bench for prt_ingress_writer: behavioural two-slot PRT, frame-level
// scoreboard (expected bytes and reports) and directed frame scenarios.
module tb_prt_ingress_writer;
    localparam int MAX_LEN = 1500;
    localparam int SLOT_W  = 1;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic              EN_start_writing_prt_entry;
    logic              RDY_start_writing_prt_entry;
    logic [SLOT_W-1:0] start_writing_prt_entry;
    logic              is_prt_slot_free;
    logic [7:0]        write_prt_entry_data;
    logic              EN_write_prt_entry;
    logic              RDY_write_prt_entry;
    logic              EN_finish_writing_prt_entry;
    logic              RDY_finish_writing_prt_entry;
    logic              frame_done;
    logic [SLOT_W-1:0] frame_slot;
    logic [10:0]       frame_len;
    logic              frame_trunc;
    logic [CNT_W-1:0]  cnt_ok;
    logic [CNT_W-1:0]  cnt_trunc;
    logic [CNT_W-1:0]  cnt_drop;

    prt_ingress_writer #(.MAX_LEN(MAX_LEN), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
        .CLK                          (CLK),
        .RST_N                        (RST_N),
        .s_data                       (s_data),
        .s_valid                      (s_valid),
        .s_last                       (s_last),
        .s_ready                      (s_ready),
        .EN_start_writing_prt_entry   (EN_start_writing_prt_entry),
        .RDY_start_writing_prt_entry  (RDY_start_writing_prt_entry),
        .start_writing_prt_entry      (start_writing_prt_entry),
        .is_prt_slot_free             (is_prt_slot_free),
        .write_prt_entry_data         (write_prt_entry_data),
        .EN_write_prt_entry           (EN_write_prt_entry),
        .RDY_write_prt_entry          (RDY_write_prt_entry),
        .EN_finish_writing_prt_entry  (EN_finish_writing_prt_entry),
        .RDY_finish_writing_prt_entry (RDY_finish_writing_prt_entry),
        .frame_done                   (frame_done),
        .frame_slot                   (frame_slot),
        .frame_len                    (frame_len),
        .frame_trunc                  (frame_trunc),
        .cnt_ok                       (cnt_ok),
        .cnt_trunc                    (cnt_trunc),
        .cnt_drop                     (cnt_drop)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({s_ready, EN_start_writing_prt_entry, EN_write_prt_entry,
                    EN_finish_writing_prt_entry, write_prt_entry_data, frame_done,
                    frame_slot, frame_len, frame_trunc, cnt_ok, cnt_trunc, cnt_drop});
    endfunction

    // ---------------- behavioural PRT: two slots, lowest free slot chosen ----------------
    localparam logic [1:0] P_IDLE = 2'd0, P_START = 2'd1, P_WRITE = 2'd2;
    logic [1:0] pst;
    logic [1:0] occ;
    logic [1:0] occ_n;
    logic [1:0] rel_mask = 2'b00;
    logic       auto_release = 1'b0;
    logic       cur_slot;
    logic       first_free;

    assign first_free                   = occ[0];
    assign is_prt_slot_free             = (occ != 2'b11);
    assign RDY_start_writing_prt_entry  = RST_N && (pst == P_IDLE) && (occ != 2'b11);
    assign start_writing_prt_entry      = (pst == P_IDLE) ? first_free : cur_slot;
    assign RDY_write_prt_entry          = (pst == P_WRITE);
    assign RDY_finish_writing_prt_entry = (pst == P_WRITE);

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pst      <= P_IDLE;
            occ      <= 2'b00;
            cur_slot <= 1'b0;
        end else begin
            occ_n = occ & ~rel_mask;
            case (pst)
                P_IDLE: if (EN_start_writing_prt_entry) begin
                    pst      <= P_START;
                    cur_slot <= first_free;
                end
                P_START: pst <= P_WRITE;
                default: if (EN_finish_writing_prt_entry) begin
                    pst <= P_IDLE;
                    if (!auto_release) occ_n[cur_slot] = 1'b1;
                end
            endcase
            occ <= occ_n;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int slot;
        int len;
        int trunc;
    } rep_t;

    logic [7:0] exp_bytes[$];
    rep_t       exp_rep[$];

    int cyc = 0, n_starts = 0, n_writes = 0, n_fin = 0, n_done = 0, n_drained = 0;
    int t_start = 0, t_fin = 0, t_done = 0;
    int exp_ok = 0, exp_trunc = 0;

    // Compare process: checks strobes, bytes and reports on every cycle
    always @(negedge CLK) begin
        if (!RST_N) begin
            exp_ok    = 0;
            exp_trunc = 0;
            exp_bytes.delete();
            exp_rep.delete();
        end else begin
            cyc++;
            if (EN_write_prt_entry && EN_finish_writing_prt_entry)
                chk("write_finish_exclusive", 64'(EN_finish_writing_prt_entry), 64'd0);
            if (EN_start_writing_prt_entry) begin
                n_starts++;
                t_start = cyc;
            end
            if (EN_finish_writing_prt_entry) begin
                n_fin++;
                t_fin = cyc;
            end
            if (s_valid && s_ready && !EN_write_prt_entry) n_drained++;
            if (EN_write_prt_entry) begin
                n_writes++;
                chk("write_needs_valid", 64'(s_valid), 64'd1);
                if (exp_bytes.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL write_unexpected: got byte 0x%0h, expected no write", write_prt_entry_data);
                end else begin
                    chk("write_data", 64'(write_prt_entry_data), 64'(exp_bytes.pop_front()));
                end
            end
            if (frame_done) begin
                n_done++;
                t_done = cyc;
                $display("frame_done slot=%0d len=%0d trunc=%0d cnt_ok=%0d cnt_trunc=%0d",
                         frame_slot, frame_len, frame_trunc, cnt_ok, cnt_trunc);
                if (exp_rep.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL done_unexpected: got frame_done len=%0d, expected none", frame_len);
                end else begin
                    rep_t r;
                    r = exp_rep.pop_front();
                    chk("frame_slot", 64'(frame_slot), 64'(r.slot));
                    chk("frame_len", 64'(frame_len), 64'(r.len));
                    chk("frame_trunc", 64'(frame_trunc), 64'(r.trunc));
                    exp_ok = (exp_ok == CNT_MAX) ? CNT_MAX : exp_ok + 1;
                    if (r.trunc != 0) exp_trunc = (exp_trunc == CNT_MAX) ? CNT_MAX : exp_trunc + 1;
                    chk("cnt_ok", 64'(cnt_ok), 64'(exp_ok));
                    chk("cnt_trunc", 64'(cnt_trunc), 64'(exp_trunc));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic release_slots(input logic [1:0] mask);
        rel_mask = mask;
        @(posedge CLK);
        #1;
        rel_mask = 2'b00;
    endtask

    // Queue the bytes the PRT must receive; a report only if the frame commits
    task automatic expect_frame(input int n, input logic [7:0] base, input int slot, input bit with_rep);
        int   w;
        rep_t r;
        w = (n > MAX_LEN) ? MAX_LEN : n;
        for (int i = 0; i < w; i++) exp_bytes.push_back(base + 8'(i));
        if (with_rep) begin
            r.slot  = slot;
            r.len   = w;
            r.trunc = (n > MAX_LEN) ? 1 : 0;
            exp_rep.push_back(r);
        end
    endtask

    // Drive one frame; optional s_valid gap before byte gap_at; stop early after abort_after bytes
    task automatic send_frame(input int n, input logic [7:0] base, input int gap_at,
                              input int gap_len, input int abort_after);
        int   i;
        int   guard;
        logic acc;
        i     = 0;
        guard = 0;
        while (i < n && i != abort_after) begin
            if (i == gap_at && gap_len > 0) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                repeat (gap_len) @(posedge CLK);
                #1;
                gap_at = -1;
            end
            s_valid = 1'b1;
            s_data  = base + 8'(i);
            s_last  = (i == n - 1);
            @(negedge CLK);
            acc = s_ready;
            @(posedge CLK);
            #1;
            if (acc) i++;
            guard++;
            if (guard > n + 4000) begin
                vectors++;
                errors++;
                $display("FAIL send_timeout: got %0d bytes accepted, expected %0d", i, n);
                break;
            end
        end
        if (i != abort_after) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    int   s0, w0, f0, d0, dr0;
    logic bp;

    initial begin
        #900000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        wait_cycles(2);

        // 64-byte frame, both slots free -> slot 0
        s0 = n_starts; w0 = n_writes; f0 = n_fin;
        expect_frame(64, 8'h10, 0, 1'b1);
        send_frame(64, 8'h10, -1, 0, -1);
        wait_cycles(4);
        chk("t1_starts", 64'(n_starts - s0), 64'd1);
        chk("t1_writes", 64'(n_writes - w0), 64'd64);
        chk("t1_finishes", 64'(n_fin - f0), 64'd1);
        chk("t1_slot", 64'(frame_slot), 64'd0);
        chk("t1_len", 64'(frame_len), 64'd64);
        chk("t1_trunc", 64'(frame_trunc), 64'd0);
        chk("t1_cnt_ok", 64'(cnt_ok), 64'd1);
        chk("t1_finish_latency", 64'(t_fin - t_start), 64'd66);
        chk("t1_done_latency", 64'(t_done - t_start), 64'd67);

        // Slot 0 now occupied; 10-byte frame with 3-cycle s_valid gap -> slot 1
        w0 = n_writes;
        expect_frame(10, 8'h40, 1, 1'b1);
        send_frame(10, 8'h40, 5, 3, -1);
        wait_cycles(4);
        chk("t2_writes", 64'(n_writes - w0), 64'd10);
        chk("t2_slot", 64'(frame_slot), 64'd1);
        chk("t2_len", 64'(frame_len), 64'd10);
        chk("t2_cnt_ok", 64'(cnt_ok), 64'd2);

        // Both slots full, 20-byte frame
        s0 = n_starts; w0 = n_writes;
`ifdef PRT_INGRESS_DROP_EN
        send_frame(20, 8'h80, -1, 0, -1);
        wait_cycles(3);
        chk("t3_no_start", 64'(n_starts - s0), 64'd0);
        chk("t3_no_writes", 64'(n_writes - w0), 64'd0);
        chk("t3_cnt_drop", 64'(cnt_drop), 64'd1);
        chk("t3_cnt_ok", 64'(cnt_ok), 64'd2);
`else
        expect_frame(20, 8'h80, 0, 1'b1);
        bp = 1'b0;
        fork
            send_frame(20, 8'h80, -1, 0, -1);
            begin
                repeat (10) begin
                    @(negedge CLK);
                    bp = bp | s_ready;
                end
                chk("t3_backpressure", 64'(bp), 64'd0);
                chk("t3_no_start_while_full", 64'(n_starts - s0), 64'd0);
                release_slots(2'b01);
            end
        join
        wait_cycles(4);
        chk("t3_writes", 64'(n_writes - w0), 64'd20);
        chk("t3_slot", 64'(frame_slot), 64'd0);
        chk("t3_len", 64'(frame_len), 64'd20);
        chk("t3_cnt_drop", 64'(cnt_drop), 64'd0);
`endif

        // 1600-byte frame -> 1500 written, 100 drained
        release_slots(2'b11);
        w0 = n_writes; dr0 = n_drained;
        expect_frame(1600, 8'h00, 0, 1'b1);
        send_frame(1600, 8'h00, -1, 0, -1);
        wait_cycles(4);
        chk("t4_writes", 64'(n_writes - w0), 64'd1500);
        chk("t4_drained", 64'(n_drained - dr0), 64'd100);
        chk("t4_slot", 64'(frame_slot), 64'd0);
        chk("t4_len", 64'(frame_len), 64'd1500);
        chk("t4_trunc", 64'(frame_trunc), 64'd1);
        chk("t4_cnt_trunc", 64'(cnt_trunc), 64'd1);

        // Reset at byte 5 of a 40-byte frame
        release_slots(2'b11);
        d0 = n_done;
        expect_frame(5, 8'h20, 0, 1'b0);
        send_frame(40, 8'h20, -1, 0, 5);
        RST_N = 1'b0;
        #1;
        chk("t5_reset_outputs", all_outs(), 64'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        wait_cycles(2);
        expect_frame(12, 8'h30, 0, 1'b1);
        send_frame(12, 8'h30, -1, 0, -1);
        wait_cycles(4);
        chk("t5_done_count", 64'(n_done - d0), 64'd1);
        chk("t5_slot", 64'(frame_slot), 64'd0);
        chk("t5_len", 64'(frame_len), 64'd12);
        chk("t5_cnt_ok", 64'(cnt_ok), 64'd1);
        chk("t5_bytes_left", 64'(exp_bytes.size()), 64'd0);

        // 2^CNT_W+2 one-byte frames -> cnt_ok saturates
        auto_release = 1'b1;
        release_slots(2'b11);
        d0 = n_done;
        for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
            expect_frame(1, 8'(k), 0, 1'b1);
            send_frame(1, 8'(k), -1, 0, -1);
        end
        wait_cycles(4);
        chk("t6_done_count", 64'(n_done - d0), 64'(18));
        chk("t6_cnt_ok_saturated", 64'(cnt_ok), 64'h0F);
        chk("t6_len", 64'(frame_len), 64'd1);
        chk("t6_reports_left", 64'(exp_rep.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/prt_ingress_writer.md
# prt_ingress_writer

Upstream feeder for the packet retention table (PRT): accepts a byte stream of frames from the receive MAC and drives the PRT's three-phase write handshake (start, write, finish) for each frame. It captures the PRT-assigned slot, truncates oversize frames, and reports each committed frame (slot, length, truncated flag) to the downstream classifier. It also keeps saturating statistics counters.

## Interface
- MAX_LEN, 1500: maximum bytes written per frame; must be ≤ PRT memory depth − 2.
- SLOT_W, 1: width of the PRT slot index.
- CNT_W, 16: width of each statistics counter.

- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_last  in  1  final byte of frame
- s_ready  out  1  byte accepted when s_valid && s_ready
- EN_start_writing_prt_entry  out  1  PRT write-start request
- RDY_start_writing_prt_entry  in  1  PRT idle with a free slot
- start_writing_prt_entry  in  SLOT_W  slot chosen by PRT
- is_prt_slot_free  in  1  PRT has at least one free slot
- write_prt_entry_data  out  8  byte to PRT
- EN_write_prt_entry  out  1  PRT byte-write strobe
- RDY_write_prt_entry  in  1  PRT accepting bytes
- EN_finish_writing_prt_entry  out  1  PRT finish strobe
- RDY_finish_writing_prt_entry  in  1  PRT can finish
- frame_done  out  1  one-cycle pulse, frame committed
- frame_slot  out  SLOT_W  slot of committed frame
- frame_len  out  11  bytes written (1..MAX_LEN)
- frame_trunc  out  1  frame exceeded MAX_LEN
- cnt_ok, cnt_trunc, cnt_drop  out  CNT_W each  saturating counters

## Operation
- States: IDLE, DATA, FINISH, DRAIN, DROP.
- IDLE:
  - s_ready=0.
  - If s_valid && RDY_start_writing_prt_entry: EN_start_writing_prt_entry=1 (combinational, one cycle) and go to DATA. The pending byte is held, not consumed.
- DATA:
  - s_ready=RDY_write_prt_entry.
  - EN_write_prt_entry=s_valid && s_ready.
  - write_prt_entry_data=s_data (combinational pass-through).
  - On the first accepted byte, latch start_writing_prt_entry into the slot register.
  - Byte counter len increments per accepted byte.
  - Accepted byte with s_last: go to FINISH, trunc=0.
  - Accepted byte with len reaching MAX_LEN and !s_last: go to FINISH, trunc=1.
- FINISH:
  - s_ready=0.
  - EN_finish_writing_prt_entry=RDY_finish_writing_prt_entry.
  - On that handshake: pulse frame_done, register frame_slot/frame_len/frame_trunc, and increment cnt_ok (and cnt_trunc if trunc).
  - Then go to DRAIN if trunc, else IDLE.
- DRAIN: s_ready=1; discard bytes; accepted s_last goes to IDLE.
- Counters saturate at all-ones; they never wrap.
- EN_write_prt_entry and EN_finish_writing_prt_entry are never asserted in the same cycle.
- The PRT memory-full auto-finish is never reached, because MAX_LEN ≤ depth − 2.

## Timing
- Reset: state IDLE, and every output is 0: s_ready, all EN_* strobes, write_prt_entry_data, frame_done, frame_slot, frame_len, frame_trunc, and all counters.
- Reset mid-frame returns to IDLE immediately. The partial frame is neither reported nor counted; the PRT is reset on the same RST_N.
- With a frame waiting, cycle T0 is EN_start and T1 is the PRT write-start cycle (RDY_write=0).
- Byte k (k=0..N−1) is written at T2+k if s_valid is continuous.
- EN_finish occurs at T2+N and frame_done at T3+N.
- Back-to-back frames: the next EN_start is possible at T3+N, once the PRT has returned to idle.
- s_valid gaps in DATA simply stall; there is no timeout.
- frame_* outputs hold until the next frame_done.

## Configuration
- PRT_INGRESS_DROP_EN defined:
  - In IDLE, s_valid && !is_prt_slot_free moves to DROP.
  - DROP: s_ready=1, discard bytes; accepted s_last increments cnt_drop and goes to IDLE.
  - A slot that frees mid-frame does not end DROP.
- PRT_INGRESS_DROP_EN undefined:
  - No DROP state; IDLE backpressures (s_ready=0) until RDY_start_writing_prt_entry.
  - cnt_drop is tied to 0.
- In both modes, a PRT that is busy (RDY_start low) while a slot is free always backpressures.

## Test plan
- 64-byte frame, continuous s_valid, PRT slot 0 free → 64 EN_write strobes carrying bytes in order, one EN_finish, frame_done with slot=0, len=64, trunc=0, cnt_ok=1.
- Slot 0 occupied and slot 1 free, 10-byte frame with s_valid deasserted for 3 cycles mid-frame → frame_slot=1, len=10, EN_write only on valid cycles.
- 1600-byte frame, MAX_LEN=1500 → exactly 1500 writes, finish, frame_trunc=1, 100 bytes drained with s_ready=1, cnt_trunc=1.
- Both slots full, 20-byte frame:
  - PRT_INGRESS_DROP_EN defined → 20 bytes consumed, no EN_start, cnt_drop=1.
  - PRT_INGRESS_DROP_EN undefined → s_ready stays 0 until a slot frees, then the frame is written normally.
- RST_N asserted at byte 5 of a 40-byte frame → all outputs 0 in the same cycle; the next frame after release is written from byte 0 with no frame_done for the aborted frame.
- cnt_ok preloaded near saturation by running 2^CNT_W+2 minimal 1-byte frames → cnt_ok holds at all-ones.
